// File: rtl/bram_mem_dual_rmw.sv
// Dual-port RMW table: read / write / add / read-and-clear per port, with built-in init sweep.
// Latency: request accepted at edge t -> DOUT/DOUT_VLD after edge t+2, write-back commits at edge t+2.
// Backpressure: none; requests seen while BUSY or CLEAR is high are dropped without a DOUT_VLD.
module bram_mem_dual_rmw #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    SATURATE   = 0
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  CLEAR,
  output logic                  BUSY,
  input  logic                  REQ_0,
  input  logic [1:0]            OP_0,
  input  logic [ADDR_WIDTH-1:0] ADDR_0,
  input  logic [DATA_WIDTH-1:0] DIN_0,
  output logic [DATA_WIDTH-1:0] DOUT_0,
  output logic                  DOUT_VLD_0,
  input  logic                  REQ_1,
  input  logic [1:0]            OP_1,
  input  logic [ADDR_WIDTH-1:0] ADDR_1,
  input  logic [DATA_WIDTH-1:0] DIN_1,
  output logic [DATA_WIDTH-1:0] DOUT_1,
  output logic                  DOUT_VLD_1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

  // New stored value for one op given the word value it sees.
  function automatic data_t apply_op(input logic [1:0] op, input data_t old_v, input data_t din);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, old_v} + {1'b0, din};
    case (op)
      2'b00:   apply_op = old_v;
      2'b01:   apply_op = din;
      2'b10:   apply_op = (SATURATE != 0 && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];
      default: apply_op = '0;
    endcase
  endfunction

  // Port-indexed views of the request inputs
  logic [1:0] req_in;
  logic [1:0] op_in   [2];
  addr_t      addr_in [2];
  data_t      din_in  [2];

  assign req_in     = {REQ_1, REQ_0};
  assign op_in[0]   = OP_0;
  assign op_in[1]   = OP_1;
  assign addr_in[0] = ADDR_0;
  assign addr_in[1] = ADDR_1;
  assign din_in[0]  = DIN_0;
  assign din_in[1]  = DIN_1;

  // Sweep / run / drain controller state
  state_t state_q;
  addr_t  sweep_q;
  logic   drain_q;
  logic   busy_q;

  // Pipeline state
  logic [1:0] s1_vld_d, s1_vld_q;
  logic [1:0] s1_op_d   [2], s1_op_q   [2];
  addr_t      s1_addr_d [2], s1_addr_q [2];
  data_t      s1_din_d  [2], s1_din_q  [2];
  logic [1:0] s2_vld_d, s2_vld_q;
  logic [1:0] s2_op_d   [2], s2_op_q   [2];
  addr_t      s2_addr_d [2], s2_addr_q [2];
  data_t      s2_din_d  [2], s2_din_q  [2];
  logic [1:0] fwd_hit_d, fwd_hit_q;
  data_t      fwd_dat_d [2], fwd_dat_q [2];
  data_t      ram_rd_q  [2];
  logic [1:0] dout_vld_d, dout_vld_q;
  data_t      dout_d    [2], dout_q    [2];

  // S2 datapath
  logic  collide;
  data_t old_0, old_1, new_0, new_1;

  // RAM write ports
  logic  we_0, we_1;
  addr_t wa_0, wa_1;
  data_t wd_0, wd_1;

  data_t mem [DEPTH];

  logic accept_ok;
  assign accept_ok = !busy_q && !CLEAR;

  // Controller: sweep every address after reset, drain two cycles before re-sweeping on CLEAR
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      drain_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + addr_t'(1);
          if (&sweep_q) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (CLEAR) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
            drain_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // S1 capture of accepted requests
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      s1_vld_d[p]  = req_in[p] && accept_ok;
      s1_op_d[p]   = op_in[p];
      s1_addr_d[p] = addr_in[p];
      s1_din_d[p]  = din_in[p];
    end
  end

  // S2 capture plus forwarding of the result being written this cycle (port 1 wins)
  always_comb begin
    s2_vld_d = s1_vld_q;
    for (int p = 0; p < 2; p++) begin
      s2_op_d[p]   = s1_op_q[p];
      s2_addr_d[p] = s1_addr_q[p];
      s2_din_d[p]  = s1_din_q[p];
      fwd_hit_d[p] = 1'b0;
      fwd_dat_d[p] = new_1;
      if (s2_vld_q[1] && s2_addr_q[1] == s1_addr_q[p]) begin
        fwd_hit_d[p] = 1'b1;
        fwd_dat_d[p] = new_1;
      end else if (s2_vld_q[0] && s2_addr_q[0] == s1_addr_q[p]) begin
        fwd_hit_d[p] = 1'b1;
        fwd_dat_d[p] = new_0;
      end
    end
  end

  // S2 old/new values; on a same-address pair port 1 operates on port 0's result
  always_comb begin
    collide = s2_vld_q[0] && s2_vld_q[1] && (s2_addr_q[0] == s2_addr_q[1]);
    old_0   = fwd_hit_q[0] ? fwd_dat_q[0] : ram_rd_q[0];
    new_0   = apply_op(s2_op_q[0], old_0, s2_din_q[0]);
    old_1   = collide ? new_0 : (fwd_hit_q[1] ? fwd_dat_q[1] : ram_rd_q[1]);
    new_1   = apply_op(s2_op_q[1], old_1, s2_din_q[1]);
  end

  // Output registers hold their last value between valid cycles
  always_comb begin
    dout_vld_d = s2_vld_q;
    dout_d[0]  = s2_vld_q[0] ? old_0 : dout_q[0];
    dout_d[1]  = s2_vld_q[1] ? old_1 : dout_q[1];
  end

  // Write-port selection: sweep borrows port 0; a colliding pair writes once via port 1
  always_comb begin
    we_0 = (state_q == ST_INIT) || (s2_vld_q[0] && !collide);
    wa_0 = (state_q == ST_INIT) ? sweep_q : s2_addr_q[0];
    wd_0 = (state_q == ST_INIT) ? INIT_VALUE : new_0;
    we_1 = s2_vld_q[1];
    wa_1 = s2_addr_q[1];
    wd_1 = new_1;
  end

  // Pipeline registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_vld_q   <= '0;
      s2_vld_q   <= '0;
      fwd_hit_q  <= '0;
      dout_vld_q <= '0;
      for (int p = 0; p < 2; p++) begin
        s1_op_q[p]   <= '0;
        s1_addr_q[p] <= '0;
        s1_din_q[p]  <= '0;
        s2_op_q[p]   <= '0;
        s2_addr_q[p] <= '0;
        s2_din_q[p]  <= '0;
        fwd_dat_q[p] <= '0;
        dout_q[p]    <= '0;
      end
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      fwd_hit_q  <= fwd_hit_d;
      dout_vld_q <= dout_vld_d;
      for (int p = 0; p < 2; p++) begin
        s1_op_q[p]   <= s1_op_d[p];
        s1_addr_q[p] <= s1_addr_d[p];
        s1_din_q[p]  <= s1_din_d[p];
        s2_op_q[p]   <= s2_op_d[p];
        s2_addr_q[p] <= s2_addr_d[p];
        s2_din_q[p]  <= s2_din_d[p];
        fwd_dat_q[p] <= fwd_dat_d[p];
        dout_q[p]    <= dout_d[p];
      end
    end
  end

  // Dual-port block RAM, read-before-write, synchronous read
  always_ff @(posedge CLK) begin
    if (we_0) mem[wa_0] <= wd_0;
    if (we_1) mem[wa_1] <= wd_1;
    ram_rd_q[0] <= mem[s1_addr_q[0]];
    ram_rd_q[1] <= mem[s1_addr_q[1]];
  end

  assign BUSY       = busy_q;
  assign DOUT_0     = dout_q[0];
  assign DOUT_1     = dout_q[1];
  assign DOUT_VLD_0 = dout_vld_q[0];
  assign DOUT_VLD_1 = dout_vld_q[1];

endmodule
